ysyx_23060203_axi_rd_arb: RTL and testbench

YSYX_23060203_AXI_RD_ARB -- requirements
Module: ysyx_23060203_axi_rd_arb

---
 rtl/ysyx_23060203_pkg.sv | 19 +
 rtl/axi_if.sv | 26 ++
 rtl/ysyx_23060203_axi_rd_mux.sv | 58 +++++
 rtl/ysyx_23060203_axi_rd_arb.sv | 102 ++++++++++
 tb/tb_ysyx_23060203_axi_rd_arb.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/ysyx_23060203_pkg.sv
// Shared types and perf event ids for the AXI read arbiter.
package ysyx_23060203_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_AR,
        ST_R
    } arb_state_t;

    typedef enum logic {
        OWN_IFU,
        OWN_LSU
    } owner_t;

    localparam int unsigned PERF_ARB_IFU_WAIT     = 0;
    localparam int unsigned PERF_ARB_LSU_WAIT     = 1;
    localparam int unsigned PERF_ARB_STARVE_FORCE = 2;

endpackage

// File: rtl/axi_if.sv
// AXI4 read-channel bundle (AR + R); 'in' is the side that accepts requests, 'out' issues them.
interface axi_if;
    logic        arvalid;
    logic        arready;
    logic [31:0] araddr;
    logic [3:0]  arid;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        rvalid;
    logic        rready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic [3:0]  rid;

    modport in (
        input  arvalid, araddr, arid, arlen, arsize, arburst, rready,
        output arready, rvalid, rdata, rresp, rlast, rid
    );

    modport out (
        output arvalid, araddr, arid, arlen, arsize, arburst, rready,
        input  arready, rvalid, rdata, rresp, rlast, rid
    );
endinterface

// File: rtl/ysyx_23060203_axi_rd_mux.sv
// Combinational AR/R steering between two requesters and the memory port, selected by owner.
module ysyx_23060203_axi_rd_mux
    import ysyx_23060203_pkg::*;
(
    input  owner_t owner,
    input  logic   ar_en,
    input  logic   r_en,
    axi_if.in      ifu,
    axi_if.in      lsu,
    axi_if.out     mem
);
    logic ar_ifu, ar_lsu, r_ifu, r_lsu;

    assign ar_ifu = ar_en && (owner == OWN_IFU);
    assign ar_lsu = ar_en && (owner == OWN_LSU);
    assign r_ifu  = r_en && (owner == OWN_IFU);
    assign r_lsu  = r_en && (owner == OWN_LSU);

    always_comb begin
        mem.arvalid = 1'b0;
        mem.araddr  = '0;
        mem.arid    = '0;
        mem.arlen   = '0;
        mem.arsize  = '0;
        mem.arburst = '0;
        if (ar_ifu) begin
            mem.arvalid = ifu.arvalid;
            mem.araddr  = ifu.araddr;
            mem.arid    = ifu.arid;
            mem.arlen   = ifu.arlen;
            mem.arsize  = ifu.arsize;
            mem.arburst = ifu.arburst;
        end else if (ar_lsu) begin
            mem.arvalid = lsu.arvalid;
            mem.araddr  = lsu.araddr;
            mem.arid    = lsu.arid;
            mem.arlen   = lsu.arlen;
            mem.arsize  = lsu.arsize;
            mem.arburst = lsu.arburst;
        end
    end

    assign ifu.arready = ar_ifu & mem.arready;
    assign lsu.arready = ar_lsu & mem.arready;
    assign mem.rready  = (r_ifu & ifu.rready) | (r_lsu & lsu.rready);

    assign ifu.rvalid = r_ifu & mem.rvalid;
    assign ifu.rdata  = r_ifu ? mem.rdata : '0;
    assign ifu.rresp  = r_ifu ? mem.rresp : '0;
    assign ifu.rlast  = r_ifu & mem.rlast;
    assign ifu.rid    = r_ifu ? mem.rid : '0;

    assign lsu.rvalid = r_lsu & mem.rvalid;
    assign lsu.rdata  = r_lsu ? mem.rdata : '0;
    assign lsu.rresp  = r_lsu ? mem.rresp : '0;
    assign lsu.rlast  = r_lsu & mem.rlast;
    assign lsu.rid    = r_lsu ? mem.rid : '0;
endmodule

// File: rtl/ysyx_23060203_axi_rd_arb.sv
// Two-requester AXI read arbiter (IFU/LSU), one outstanding read, LSU priority with IFU anti-starvation.
// Optional perf hooks under YSYX_23060203_ARB_PERF_EN (never under SYNTHESIS).
module ysyx_23060203_axi_rd_arb
    import ysyx_23060203_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic clock,
    input  logic reset,
    axi_if.in    ifu_r,
    axi_if.in    lsu_r,
    axi_if.out   mem_r
);
    localparam int unsigned    CntW   = $clog2(STARVE_LIMIT + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(STARVE_LIMIT);

    arb_state_t      state_q, state_d;
    owner_t          owner_q, owner_d;
    logic [CntW-1:0] starve_q, starve_d;
    logic            force_ifu;

    assign force_ifu = ifu_r.arvalid & lsu_r.arvalid & (starve_q == CntMax);

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        starve_d = starve_q;
        unique case (state_q)
            ST_IDLE: begin
                if (ifu_r.arvalid || lsu_r.arvalid) begin
                    state_d = ST_AR;
                    if (lsu_r.arvalid && !force_ifu) begin
                        owner_d = OWN_LSU;
                        if (ifu_r.arvalid && (starve_q != CntMax)) begin
                            starve_d = starve_q + 1'b1;
                        end
                    end else begin
                        owner_d  = OWN_IFU;
                        starve_d = '0;
                    end
                end
            end
            ST_AR: begin
                if (mem_r.arvalid && mem_r.arready) state_d = ST_R;
            end
            ST_R: begin
                if (mem_r.rvalid && mem_r.rready && mem_r.rlast) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            owner_q  <= OWN_IFU;
            starve_q <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            starve_q <= starve_d;
        end
    end

    ysyx_23060203_axi_rd_mux u_mux (
        .owner (owner_q),
        .ar_en (state_q == ST_AR),
        .r_en  (state_q == ST_R),
        .ifu   (ifu_r),
        .lsu   (lsu_r),
        .mem   (mem_r)
    );

`ifdef YSYX_23060203_ARB_PERF_EN
`ifndef SYNTHESIS
    int unsigned perf_cnt [3];

    initial begin
        for (int i = 0; i < 3; i++) perf_cnt[i] = 0;
    end

    function automatic void perf_event(input int unsigned id);
        if (id < 3) perf_cnt[id] = perf_cnt[id] + 1;
    endfunction

    // A requester is waiting whenever it holds arvalid but is not the one in ST_AR.
    always @(posedge clock) begin
        if (reset) begin
            if (ifu_r.arvalid && !(state_q == ST_AR && owner_q == OWN_IFU)) begin
                perf_event(PERF_ARB_IFU_WAIT);
            end
            if (lsu_r.arvalid && !(state_q == ST_AR && owner_q == OWN_LSU)) begin
                perf_event(PERF_ARB_LSU_WAIT);
            end
            if (state_q == ST_IDLE && force_ifu) begin
                perf_event(PERF_ARB_STARVE_FORCE);
            end
        end
    end
`endif
`endif
endmodule

// File: tb/tb_ysyx_23060203_axi_rd_arb.sv
// Directed bench for the AXI read arbiter: cycle table plus corner-case sequences.
module tb_ysyx_23060203_axi_rd_arb;
    import ysyx_23060203_pkg::*;

    logic clock = 1'b0;
    logic reset = 1'b0;

    axi_if ifu_r();
    axi_if lsu_r();
    axi_if mem_r();

    ysyx_23060203_axi_rd_arb #(.STARVE_LIMIT(4)) dut (
        .clock (clock),
        .reset (reset),
        .ifu_r (ifu_r),
        .lsu_r (lsu_r),
        .mem_r (mem_r)
    );

    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;

    // in  = {ifu arvalid, lsu arvalid, mem arready, mem rvalid, mem rlast, ifu rready, lsu rready}
    // exp = {mem arvalid, ifu arready, lsu arready, ifu rvalid, lsu rvalid, mem rready}
    typedef struct {
        logic [6:0]  in;
        logic [31:0] ia;
        logic [5:0]  exp;
        logic [31:0] eaddr;
    } vec_t;

    vec_t vecs[15];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [6:0] b);
        ifu_r.arvalid = b[6];
        lsu_r.arvalid = b[5];
        mem_r.arready = b[4];
        mem_r.rvalid  = b[3];
        mem_r.rlast   = b[2];
        ifu_r.rready  = b[1];
        lsu_r.rready  = b[0];
    endtask

    function automatic logic [5:0] outs();
        return {mem_r.arvalid, ifu_r.arready, lsu_r.arready,
                ifu_r.rvalid, lsu_r.rvalid, mem_r.rready};
    endfunction

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic        exp_lsu;
        logic        irr;
        int          n;
        int          k;
        logic [31:0] recv[4];

        drive(7'b0);
        ifu_r.araddr = 32'h3000_0000; ifu_r.arid = 4'h1; ifu_r.arlen = 8'd3;
        ifu_r.arsize = 3'd2; ifu_r.arburst = 2'b01;
        lsu_r.araddr = 32'h8000_1000; lsu_r.arid = 4'h2; lsu_r.arlen = 8'd0;
        lsu_r.arsize = 3'd2; lsu_r.arburst = 2'b01;
        mem_r.rdata = 32'h0; mem_r.rresp = 2'b00; mem_r.rid = 4'h0;

        vecs[0]  = '{7'b0000000, 32'h3000_0000, 6'b000000, 32'h0};
        vecs[1]  = '{7'b1000000, 32'h3000_0000, 6'b000000, 32'h0};
        vecs[2]  = '{7'b1000000, 32'h3000_0000, 6'b100000, 32'h3000_0000};
        vecs[3]  = '{7'b1010000, 32'h3000_0000, 6'b110000, 32'h3000_0000};
        vecs[4]  = '{7'b0001010, 32'h3000_0000, 6'b000101, 32'h0};
        vecs[5]  = '{7'b0001010, 32'h3000_0000, 6'b000101, 32'h0};
        vecs[6]  = '{7'b0001010, 32'h3000_0000, 6'b000101, 32'h0};
        vecs[7]  = '{7'b0001110, 32'h3000_0000, 6'b000101, 32'h0};
        vecs[8]  = '{7'b0000000, 32'h3000_0000, 6'b000000, 32'h0};
        vecs[9]  = '{7'b1100000, 32'h8000_0000, 6'b000000, 32'h0};
        vecs[10] = '{7'b1110000, 32'h8000_0000, 6'b101000, 32'h8000_1000};
        vecs[11] = '{7'b1001101, 32'h8000_0000, 6'b000011, 32'h0};
        vecs[12] = '{7'b1000000, 32'h8000_0000, 6'b000000, 32'h0};
        vecs[13] = '{7'b1010000, 32'h8000_0000, 6'b110000, 32'h8000_0000};
        vecs[14] = '{7'b0001110, 32'h8000_0000, 6'b000101, 32'h0};

        // Reset state
        #12;
        check("rst_outs", 64'(outs()), 64'd0);
        check("rst_state", 64'(dut.state_q), 64'(ST_IDLE));
        check("rst_owner", 64'(dut.owner_q), 64'(OWN_IFU));
        check("rst_starve", 64'(dut.starve_q), 64'd0);
        @(negedge clock);
        reset = 1'b1;

        // IFU-only burst, then simultaneous IFU/LSU requests
        for (int i = 0; i < 15; i++) begin
            @(negedge clock);
            drive(vecs[i].in);
            ifu_r.araddr = vecs[i].ia;
            #1;
            check($sformatf("vec%0d", i), {outs(), mem_r.araddr}, {vecs[i].exp, vecs[i].eaddr});
        end

        // Starvation: 4 LSU grants while IFU waits, then IFU is forced, then LSU again
        for (int g = 0; g < 6; g++) begin
            exp_lsu = (g != 4);
            @(negedge clock);
            drive(7'b1110000);
            #1;
            check($sformatf("starve%0d_idle", g), 64'(outs()), 64'd0);
            @(negedge clock);
            #1;
            check($sformatf("starve%0d_ar", g), {ifu_r.arready, lsu_r.arready},
                  {!exp_lsu, exp_lsu});
            if (g == 4) check("starve_cnt_clr", 64'(dut.starve_q), 64'd0);
            @(negedge clock);
            drive(7'b1101111);
            #1;
            check($sformatf("starve%0d_r", g),
                  {ifu_r.rvalid, lsu_r.rvalid, ifu_r.arready, lsu_r.arready},
                  {!exp_lsu, exp_lsu, 2'b00});
        end
        @(negedge clock);
        drive(7'b0);

        // Backpressure: arready low 5 cycles, then IFU rready toggles
        ifu_r.araddr = 32'h3000_0000;
        @(negedge clock);
        drive(7'b1000000);
        #1;
        check("bp_idle", 64'(outs()), 64'd0);
        for (int c = 0; c < 5; c++) begin
            @(negedge clock);
            #1;
            check($sformatf("bp_stall%0d", c), {mem_r.arvalid, ifu_r.arready}, 2'b10);
        end
        @(negedge clock);
        mem_r.arready = 1'b1;
        #1;
        check("bp_ar", {ifu_r.arready, mem_r.arlen, mem_r.araddr},
              {1'b1, 8'd3, 32'h3000_0000});
        n = 0;
        k = 0;
        for (int c = 0; c < 20 && n < 4; c++) begin
            @(negedge clock);
            irr = c[0];
            drive({4'b0001, (k == 3), irr, 1'b0});
            mem_r.rdata = 32'hD000_0000 + k;
            #1;
            check($sformatf("bp_cyc%0d", c), {ifu_r.rvalid, mem_r.rready, ifu_r.rdata},
                  {1'b1, irr, 32'hD000_0000 + 32'(k)});
            if (ifu_r.rvalid && irr) begin
                recv[n] = ifu_r.rdata;
                n++;
                k++;
            end
        end
        check("bp_count", 64'(n), 64'd4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("bp_order%0d", i), 64'(recv[i]), 64'(32'hD000_0000 + 32'(i)));
        end
        @(negedge clock);
        drive(7'b0001010);
        #1;
        check("bp_done_idle", {ifu_r.rvalid, mem_r.rready}, 2'b00);

        // Reset mid-burst, then a fresh LSU request
        lsu_r.arlen = 8'd3;
        @(negedge clock);
        drive(7'b0100000);
        @(negedge clock);
        drive(7'b0110000);
        #1;
        check("rm_ar", {lsu_r.arready, mem_r.arlen}, {1'b1, 8'd3});
        for (int b = 0; b < 2; b++) begin
            @(negedge clock);
            drive(7'b0001001);
            #1;
            check($sformatf("rm_beat%0d", b), {lsu_r.rvalid, mem_r.rready}, 2'b11);
        end
        @(negedge clock);
        reset = 1'b0;
        drive(7'b0111001);
        #1;
        check("rm_assert", 64'(outs()), 64'd0);
        @(negedge clock);
        #1;
        check("rm_hold", 64'(outs()), 64'd0);
        @(negedge clock);
        reset = 1'b1;
        lsu_r.arlen = 8'd0;
        drive(7'b0100000);
        #1;
        check("rm_release", 64'(outs()), 64'd0);
        @(negedge clock);
        drive(7'b0110000);
        #1;
        check("rm_regrant", {outs(), mem_r.araddr}, {6'b101000, 32'h8000_1000});
        @(negedge clock);
        drive(7'b0001101);
        #1;
        check("rm_rbeat", 64'(outs()), 64'(6'b000011));

        // Error response pass-through
        @(negedge clock);
        drive(7'b0100000);
        @(negedge clock);
        drive(7'b0110000);
        @(negedge clock);
        drive(7'b0001101);
        mem_r.rresp = 2'b10;
        #1;
        check("err_resp", {lsu_r.rvalid, lsu_r.rresp, lsu_r.rlast}, {1'b1, 2'b10, 1'b1});
        @(negedge clock);
        drive(7'b0001001);
        #1;
        check("err_idle", {lsu_r.rvalid, mem_r.arvalid, mem_r.rready}, 3'b000);
        @(negedge clock);
        drive(7'b0);
        mem_r.rresp = 2'b00;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
